microblaze_bram_burst_master: RTL and testbench
===============================================

# microblaze_bram_burst_master

Initiator for one port of the MicroBlaze local BRAM block. It drives a port's EN/WEN/Addr/Dout and captures Din, turning a valid/ready burst-command interface into one-word-per-cycle BRAM accesses. It sits between a DMA or peripheral engine and port B of the BRAM block, so that engine can fill or drain processor-visible memory without going through the LMB.

## Interface

**Parameters**
- C_BASEADDR, 'h0000_0000: byte address of BRAM word 0, as seen on Cmd_Addr and BRAM_Addr_A.
- C_MEMSIZE, 'h2000: BRAM size in bytes; must be a power of two.
- C_PORT_AWIDTH, 32: address width.
- C_PORT_DWIDTH, 32: data width.
- C_NUM_WE, 4: number of byte write enables.
- C_LEN_WIDTH, 8: width of Cmd_Len.

**Ports** (all vectors use [0:N-1] big-endian numbering)
- Clk  in  1  block clock; also forwarded unchanged to BRAM_Clk_A.
- Rst  in  1  synchronous, active-high reset; also forwarded to BRAM_Rst_A.
- Cmd_Valid / Cmd_Ready  in/out  1  command handshake.
- Cmd_Write  in  1  1 = write burst, 0 = read burst.
- Cmd_Addr  in  C_PORT_AWIDTH  start byte address, word-aligned.
- Cmd_Len  in  C_LEN_WIDTH  beats minus 1.
- Cmd_BE  in  C_NUM_WE  byte enables, applied to every write beat.
- Wr_Valid / Wr_Ready  in/out  1  write-data handshake.
- Wr_Data  in  C_PORT_DWIDTH  write beat.
- Rd_Valid / Rd_Ready  out/in  1  read-data handshake.
- Rd_Data  out  C_PORT_DWIDTH  read beat.
- Rd_Last  out  1  marks the final beat of a read burst.
- Busy  out  1  high whenever the state is not IDLE.
- Err  out  1  one-cycle pulse when a command is rejected.
- BRAM_Clk_A, BRAM_Rst_A  out  1  forwarded clock and reset.
- BRAM_EN_A  out  1  port enable.
- BRAM_WEN_A  out  C_NUM_WE  byte write enables.
- BRAM_Addr_A  out  C_PORT_AWIDTH  word byte address.
- BRAM_Dout_A  out  C_PORT_DWIDTH  data written into the BRAM.
- BRAM_Din_A  in  C_PORT_DWIDTH  data read from the BRAM.

## Operation

**States**
- IDLE
  - Cmd_Ready=1.
  - On Cmd_Valid: latch offset = Cmd_Addr−C_BASEADDR, beat counter = Cmd_Len, and BE.
  - Go to WRITE if Cmd_Write=1, otherwise READ.
- WRITE
  - Wr_Ready=1.
  - Each Wr_Valid&Wr_Ready issues one write beat, then offset += 4 and the counter decrements.
  - After the last beat, go to IDLE.
- READ
  - Issues one read beat per cycle while (FIFO occupancy + in-flight) < 4.
  - After the last issue, go to DRAIN.
- DRAIN
  - Issues no further beats.
  - Go to IDLE once in-flight = 0 and the FIFO is empty, i.e. after the Rd_Last handshake.

**Datapath rules**
- Offset arithmetic is modulo C_MEMSIZE, so a burst that crosses the top of memory wraps to C_BASEADDR.
- BRAM_Addr_A = C_BASEADDR + offset.
- Cmd_Addr[30:31] are not used as an address offset.
- The read path has a 4-entry FIFO and at most 2 beats in flight, both pipeline stages included.
- BRAM_EN_A, BRAM_WEN_A, BRAM_Addr_A and BRAM_Dout_A are registered.
  - Outside an issued beat, EN and WEN are 0.
  - Outside an issued beat, Addr and Dout hold their last value.
- Read beats drive WEN=0.
- Rd_Last is asserted together with the head beat when that beat is the final one of the burst.

**Reset**
- Rst=1 forces IDLE, flushes the FIFO, and clears in-flight beats and counters.
- All outputs reset to 0; Cmd_Ready is 1 from the first cycle after Rst falls.
- A reset mid-burst abandons the burst; writes already issued remain in the BRAM.

## Timing

- **Write beat:** a Wr handshake in cycle N gives BRAM_EN_A=1, WEN=BE, Addr and Dout in cycle N+1. The memory updates at the edge ending cycle N+1.
- **Read burst first-beat latency:**
  - Cmd handshake in cycle 0.
  - Issue decision in cycle 1; BRAM_EN_A in cycle 2.
  - BRAM_Din_A valid in cycle 3 and captured into the FIFO.
  - Rd_Valid in cycle 4.
- **Read throughput:** one beat per cycle sustained while Rd_Ready=1.
- **Read backpressure:** Rd_Valid, Rd_Data and Rd_Last hold stable while Rd_Valid=1 and Rd_Ready=0.
- **Write throughput:** one beat per cycle sustained while Wr_Valid=1.
- **Command turnaround:** Cmd_Ready returns the cycle after the transition to IDLE. The earliest back-to-back write command is accepted 1 cycle after the last Wr handshake.
- **Single-beat bursts:** Cmd_Len=0 gives a one-beat burst.
- **Simultaneous events:** a FIFO push and pop in the same cycle leave occupancy unchanged.

## Configuration

BRAM_ADDR_CHECK_EN
- **Defined:**
  - In IDLE, a command is rejected when Cmd_Addr[30:31]≠0 or Cmd_Addr is outside [C_BASEADDR, C_BASEADDR+C_MEMSIZE).
  - A rejected command is still consumed, Err pulses for 1 cycle, no BRAM access occurs, and the state stays IDLE.
- **Undefined:**
  - Err is tied to 0 and no command is rejected.
  - The offset is taken modulo C_MEMSIZE, and the low 2 bits are dropped.

## Test plan

- **Reset:** Rst high for 2 cycles mid-idle → every output 0 during reset; Cmd_Ready=1 the cycle after Rst falls.
- **Write burst:**
  - Stimulus: Addr 0x10, Len 3, BE 1111, Wr_Valid held high with data 0xA0..0xA3.
  - Required: BRAM_EN_A and WEN=1111 on 4 consecutive cycles at Addr 0x10/0x14/0x18/0x1C with Dout 0xA0..0xA3; Busy falls after the last beat.
- **Read burst under stall:**
  - Stimulus: Addr 0x10, Len 7, memory preloaded with word index; Rd_Ready low for cycles 5–10.
  - Required: never more than 4 beats held or in flight, no beat lost; data 4..11 in order; Rd_Last only on the 8th beat; first Rd_Valid in cycle 4.
- **Wrap:** Addr 0x1FF8, Len 3 (read and write) → BRAM_Addr_A sequence 0x1FF8, 0x1FFC, 0x0000, 0x0004.
- **Rejection (macro defined):** Cmd_Addr 0x2000, then 0x0002 → Err 1-cycle pulse for each, no BRAM_EN_A, Busy stays 0.
- **Reset mid-read:** Rst during cycle 6 of a Len 15 read → Rd_Valid=0 and FIFO empty after reset; a new Len 0 read then returns the correct single beat with Rd_Last=1.

Source files
------------

// File: rtl/microblaze_bram_burst_master.sv
// microblaze_bram_burst_master
//   Burst initiator for one port of the MicroBlaze local BRAM block. A
//   valid/ready command (start address, beat count, byte enables) becomes a
//   stream of one-word-per-cycle BRAM accesses. Write beats come from the
//   Wr_* stream. Read beats are returned through a 4-entry FIFO on the Rd_*
//   stream.
//
//   Optional feature macro: BRAM_ADDR_CHECK_EN
//     defined   : commands that are misaligned or outside the memory window
//                 are consumed, pulse Err for one cycle and cause no access.
//     undefined : Err is tied low. The offset is folded modulo C_MEMSIZE and
//                 its low two bits are dropped.
//
// Ports
//   Clk, Rst                     clock, synchronous active-high reset
//   Cmd_Valid/Ready/Write/Addr/Len/BE   burst command (Len = beats-1)
//   Wr_Valid/Ready/Data          write beat stream
//   Rd_Valid/Ready/Data/Last     read beat stream
//   Busy, Err                    status: not idle / command rejected pulse
//   BRAM_Clk_A, BRAM_Rst_A       forwarded Clk / Rst
//   BRAM_EN_A/WEN_A/Addr_A/Dout_A registered BRAM port drive
//   BRAM_Din_A                   BRAM read data, one cycle after EN

module microblaze_bram_burst_master #(
  parameter int unsigned C_BASEADDR    = 'h0000_0000,
  parameter int unsigned C_MEMSIZE     = 'h2000,
  parameter int          C_PORT_AWIDTH = 32,
  parameter int          C_PORT_DWIDTH = 32,
  parameter int          C_NUM_WE      = 4,
  parameter int          C_LEN_WIDTH   = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Cmd_Valid,
  output logic                     Cmd_Ready,
  input  logic                     Cmd_Write,
  input  logic [0:C_PORT_AWIDTH-1] Cmd_Addr,
  input  logic [0:C_LEN_WIDTH-1]   Cmd_Len,
  input  logic [0:C_NUM_WE-1]      Cmd_BE,
  input  logic                     Wr_Valid,
  output logic                     Wr_Ready,
  input  logic [0:C_PORT_DWIDTH-1] Wr_Data,
  output logic                     Rd_Valid,
  input  logic                     Rd_Ready,
  output logic [0:C_PORT_DWIDTH-1] Rd_Data,
  output logic                     Rd_Last,
  output logic                     Busy,
  output logic                     Err,
  output logic                     BRAM_Clk_A,
  output logic                     BRAM_Rst_A,
  output logic                     BRAM_EN_A,
  output logic [0:C_NUM_WE-1]      BRAM_WEN_A,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr_A,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout_A,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din_A
);

  localparam int OFS_W  = $clog2(C_MEMSIZE);
  // vld_pipe[0]: access on the BRAM port, vld_pipe[1]: Din valid this cycle
  localparam int STAGES = 1;
  localparam int FDEPTH = 4;
  localparam logic [C_PORT_AWIDTH-1:0] BASE = C_PORT_AWIDTH'(C_BASEADDR);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  state_t                   state;
  logic                     cmd_ready;
  logic                     wr_ready;
  logic [OFS_W-1:0]         ofs;
  logic [C_LEN_WIDTH-1:0]   beats;
  logic [0:C_NUM_WE-1]      be_q;
  logic [STAGES:0]          vld_pipe;
  logic [STAGES:0]          last_pipe;

  logic [0:C_PORT_DWIDTH-1] f_data [FDEPTH];
  logic                     f_last [FDEPTH];
  logic [1:0]               wp, rp;
  logic [2:0]               cnt;

  logic [OFS_W-1:0]         cmd_ofs, ofs_nxt;
  logic [C_PORT_AWIDTH-1:0] addr_cur;
  logic                     cmd_ok, cmd_hs, issue, push, pop, drain_done;

  // Offset is a byte offset with the low two bits forced to zero; adding 4
  // and truncating to OFS_W bits is the wrap at the top of memory.
  assign cmd_ofs  = OFS_W'(Cmd_Addr - BASE) & ~OFS_W'(3);
  assign ofs_nxt  = ofs + OFS_W'(4);
  assign addr_cur = BASE + C_PORT_AWIDTH'(ofs);

`ifdef BRAM_ADDR_CHECK_EN
  localparam int AW1 = C_PORT_AWIDTH + 1;
  logic [AW1-1:0] span;
  logic           err_q;
  // One extra bit so an address below the base wraps to a huge span.
  assign span   = {1'b0, Cmd_Addr} - {1'b0, BASE};
  assign cmd_ok = (Cmd_Addr[C_PORT_AWIDTH-2:C_PORT_AWIDTH-1] == 2'b00) &&
                  (span < AW1'(C_MEMSIZE));
  always_ff @(posedge Clk) begin
    if (Rst) err_q <= 1'b0;
    else     err_q <= cmd_hs && !cmd_ok;
  end
  assign Err = err_q;
`else
  assign cmd_ok = 1'b1;
  assign Err    = 1'b0;
`endif

  assign cmd_hs = (state == S_IDLE) && Cmd_Valid && cmd_ready;

  // Issue only while everything already issued still has a FIFO slot; the
  // current pop is ignored on purpose, which still sustains 1 beat/cycle.
  assign issue = (state == S_READ) &&
                 ((cnt + 3'(vld_pipe[0]) + 3'(vld_pipe[1])) < 3'(FDEPTH));
  assign push  = vld_pipe[STAGES];
  assign pop   = Rd_Valid && Rd_Ready;

  // Leave DRAIN on the edge that pops the final beat.
  assign drain_done = (vld_pipe == '0) &&
                      ((cnt == 3'd0) || ((cnt == 3'd1) && pop));

  assign Cmd_Ready  = cmd_ready;
  assign Wr_Ready   = wr_ready;
  assign Busy       = (state != S_IDLE);
  assign Rd_Valid   = (cnt != 3'd0);
  assign Rd_Data    = f_data[rp];
  assign Rd_Last    = Rd_Valid && f_last[rp];
  assign BRAM_Clk_A = Clk;
  assign BRAM_Rst_A = Rst;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b0;
      wr_ready    <= 1'b0;
      ofs         <= '0;
      beats       <= '0;
      be_q        <= '0;
      vld_pipe    <= '0;
      last_pipe   <= '0;
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
      BRAM_EN_A   <= 1'b0;
      BRAM_WEN_A  <= '0;
      BRAM_Addr_A <= '0;
      BRAM_Dout_A <= '0;
      for (int i = 0; i < FDEPTH; i++) begin
        f_data[i] <= '0;
        f_last[i] <= 1'b0;
      end
    end else begin
      BRAM_EN_A  <= 1'b0;
      BRAM_WEN_A <= '0;
      vld_pipe   <= {vld_pipe[STAGES-1:0], issue};
      last_pipe  <= {last_pipe[STAGES-1:0], issue && (beats == '0)};

      // Read return FIFO; the capture stage carries the burst-end flag.
      if (push) begin
        f_data[wp] <= BRAM_Din_A;
        f_last[wp] <= last_pipe[STAGES];
        wp         <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      cnt <= cnt + 3'(push) - 3'(pop);

      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_hs && cmd_ok) begin
            cmd_ready <= 1'b0;
            ofs       <= cmd_ofs;
            beats     <= Cmd_Len;
            be_q      <= Cmd_BE;
            wr_ready  <= Cmd_Write;
            state     <= Cmd_Write ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (Wr_Valid && wr_ready) begin
            BRAM_EN_A   <= 1'b1;
            BRAM_WEN_A  <= be_q;
            BRAM_Addr_A <= addr_cur;
            BRAM_Dout_A <= Wr_Data;
            ofs         <= ofs_nxt;
            if (beats == '0) begin
              wr_ready  <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              beats <= beats - C_LEN_WIDTH'(1);
            end
          end
        end
        S_READ: begin
          if (issue) begin
            BRAM_EN_A   <= 1'b1;
            BRAM_Addr_A <= addr_cur;
            ofs         <= ofs_nxt;
            if (beats == '0) state <= S_DRAIN;
            else             beats <= beats - C_LEN_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_microblaze_bram_burst_master.sv
// Directed bench for microblaze_bram_burst_master with a behavioural
// read-first BRAM (8 KiB, word i preloaded with i).
module tb_microblaze_bram_burst_master;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Cmd_Valid = 1'b0, Cmd_Ready, Cmd_Write = 1'b0;
  logic [0:31] Cmd_Addr = '0;
  logic [0:7]  Cmd_Len = '0;
  logic [0:3]  Cmd_BE = '0;
  logic        Wr_Valid = 1'b0, Wr_Ready;
  logic [0:31] Wr_Data = '0;
  logic        Rd_Valid, Rd_Ready = 1'b1, Rd_Last;
  logic [0:31] Rd_Data;
  logic        Busy, Err, BRAM_Clk_A, BRAM_Rst_A, BRAM_EN_A;
  logic [0:3]  BRAM_WEN_A;
  logic [0:31] BRAM_Addr_A, BRAM_Dout_A;
  logic [0:31] BRAM_Din_A = '0;

  microblaze_bram_burst_master dut (
    .Clk(Clk), .Rst(Rst),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Write(Cmd_Write),
    .Cmd_Addr(Cmd_Addr), .Cmd_Len(Cmd_Len), .Cmd_BE(Cmd_BE),
    .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Wr_Data(Wr_Data),
    .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready), .Rd_Data(Rd_Data), .Rd_Last(Rd_Last),
    .Busy(Busy), .Err(Err),
    .BRAM_Clk_A(BRAM_Clk_A), .BRAM_Rst_A(BRAM_Rst_A), .BRAM_EN_A(BRAM_EN_A),
    .BRAM_WEN_A(BRAM_WEN_A), .BRAM_Addr_A(BRAM_Addr_A), .BRAM_Dout_A(BRAM_Dout_A),
    .BRAM_Din_A(BRAM_Din_A)
  );

  always #5 Clk = ~Clk;

  // BRAM model: read-first, byte lane 0 is the most significant byte.
  logic [31:0] mem [2048];
  always @(posedge Clk) begin
    if (BRAM_EN_A) begin
      BRAM_Din_A <= mem[(BRAM_Addr_A >> 2) & 32'h7FF];
      for (int b = 0; b < 4; b++)
        if (BRAM_WEN_A[b]) mem[(BRAM_Addr_A >> 2) & 32'h7FF][31-8*b -: 8] <= BRAM_Dout_A[8*b +: 8];
    end
  end

  int n_cmp = 0, n_err = 0;
  int cyc = 0, t0 = 0;
  int st_lo = 1, st_hi = 0;
  int first_rv, busy_fall, issued, popped, max_out, hold_bad, wi, wn;
  logic busy_prev, busy_any, hold_chk;
  logic [0:31] h_data;
  logic h_last;
  logic [31:0] wdat [4];
  int          acc_rel [$];
  logic [31:0] acc_addr [$], acc_dout [$];
  logic [3:0]  acc_wen [$];
  logic [31:0] rb_data [$];
  logic        rb_last [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    acc_rel.delete(); acc_addr.delete(); acc_dout.delete(); acc_wen.delete();
    rb_data.delete(); rb_last.delete();
    first_rv = -1; busy_fall = -1; issued = 0; popped = 0; max_out = 0;
    hold_bad = 0; hold_chk = 1'b0; busy_prev = 1'b0; busy_any = 1'b0;
    wi = 0; wn = 0; t0 = cyc;
  endtask

  // One cycle: sample outputs at the falling edge, then drive the stream
  // inputs for the edge that ends this cycle.
  task automatic tick();
    @(negedge Clk);
    cyc++;
    if (BRAM_EN_A) begin
      acc_rel.push_back(cyc - t0); acc_addr.push_back(BRAM_Addr_A);
      acc_wen.push_back(BRAM_WEN_A); acc_dout.push_back(BRAM_Dout_A);
      if (BRAM_WEN_A == 4'h0) issued++;
    end
    if (issued - popped > max_out) max_out = issued - popped;
    if (Rst) hold_chk = 1'b0;
    if (hold_chk && (!Rd_Valid || Rd_Data !== h_data || Rd_Last !== h_last)) hold_bad++;
    Rd_Ready = !((cyc - t0) >= st_lo && (cyc - t0) <= st_hi);
    hold_chk = Rd_Valid && !Rd_Ready;
    h_data = Rd_Data; h_last = Rd_Last;
    if (Rd_Valid && first_rv < 0) first_rv = cyc - t0;
    if (Rd_Valid && Rd_Ready) begin
      rb_data.push_back(Rd_Data); rb_last.push_back(Rd_Last); popped++;
    end
    Wr_Valid = (wi < wn);
    if (wi < wn) Wr_Data = wdat[wi];
    if (Wr_Valid && Wr_Ready) wi++;
    busy_any = busy_any | Busy;
    if (busy_prev && !Busy && busy_fall < 0) busy_fall = cyc - t0;
    busy_prev = Busy;
  endtask

  // Present a command; t0 becomes the handshake cycle.
  task automatic cmd(input logic w, input logic [31:0] a, input logic [7:0] len);
    int k;
    Cmd_Valid = 1'b1; Cmd_Write = w; Cmd_Addr = a; Cmd_Len = len; Cmd_BE = 4'hF;
    k = 0;
    while (!Cmd_Ready && k < 20) begin tick(); k++; end
    if (!Cmd_Ready) chk("cmd_timeout", 0, 1);
    t0 = cyc;
    tick();
    Cmd_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (Busy && k < 200) begin tick(); k++; end
    if (Busy) chk("idle_timeout", 1, 0);
    tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = i;

    // Power-on reset, then Cmd_Ready one cycle after Rst is seen low.
    clr();
    repeat (3) tick();
    Rst = 1'b0;
    tick();
    chk("por_cmd_ready", Cmd_Ready, 1);
    chk("por_busy", Busy, 0);

    // Read burst 0x10, 8 beats, Rd_Ready low for cycles 5..10.
    clr();
    st_lo = 5; st_hi = 10;
    cmd(1'b0, 32'h10, 8'd7);
    wait_idle();
    st_lo = 1; st_hi = 0;
    chk("rd_first_en", acc_rel[0], 2);
    chk("rd_first_valid", first_rv, 4);
    chk("rd_beats", rb_data.size(), 8);
    for (int i = 0; i < 8 && i < rb_data.size(); i++) begin
      chk($sformatf("rd_data%0d", i), rb_data[i], 4 + i);
      chk($sformatf("rd_last%0d", i), rb_last[i], (i == 7));
    end
    chk("rd_max_outstanding_le4", max_out <= 4, 1);
    chk("rd_hold_stable", hold_bad, 0);

    // Write burst 0x10, 4 beats of A0..A3.
    clr();
    wdat[0] = 32'hA0; wdat[1] = 32'hA1; wdat[2] = 32'hA2; wdat[3] = 32'hA3; wn = 4;
    cmd(1'b1, 32'h10, 8'd3);
    wait_idle();
    chk("wr_accesses", acc_rel.size(), 4);
    for (int i = 0; i < 4 && i < acc_rel.size(); i++) begin
      chk($sformatf("wr_cyc%0d", i), acc_rel[i], 2 + i);
      chk($sformatf("wr_addr%0d", i), acc_addr[i], 32'h10 + 4*i);
      chk($sformatf("wr_dout%0d", i), acc_dout[i], 32'hA0 + i);
      chk($sformatf("wr_wen%0d", i), acc_wen[i], 4'hF);
    end
    chk("wr_busy_fall", busy_fall, 5);
    chk("wr_mem5", mem[5], 32'hA1);

    // Wrapping write then read at 0x1FF8.
    clr();
    wdat[0] = 32'hB0; wdat[1] = 32'hB1; wdat[2] = 32'hB2; wdat[3] = 32'hB3; wn = 4;
    cmd(1'b1, 32'h1FF8, 8'd3);
    wait_idle();
    chk("wwrap_n", acc_addr.size(), 4);
    if (acc_addr.size() == 4) begin
      chk("wwrap_a0", acc_addr[0], 32'h1FF8); chk("wwrap_a1", acc_addr[1], 32'h1FFC);
      chk("wwrap_a2", acc_addr[2], 32'h0000); chk("wwrap_a3", acc_addr[3], 32'h0004);
    end
    clr();
    cmd(1'b0, 32'h1FF8, 8'd3);
    wait_idle();
    chk("rwrap_n", acc_addr.size(), 4);
    if (acc_addr.size() == 4) begin
      chk("rwrap_a0", acc_addr[0], 32'h1FF8); chk("rwrap_a1", acc_addr[1], 32'h1FFC);
      chk("rwrap_a2", acc_addr[2], 32'h0000); chk("rwrap_a3", acc_addr[3], 32'h0004);
    end
    chk("rwrap_beats", rb_data.size(), 4);
    for (int i = 0; i < 4 && i < rb_data.size(); i++) begin
      chk($sformatf("rwrap_data%0d", i), rb_data[i], 32'hB0 + i);
      chk($sformatf("rwrap_last%0d", i), rb_last[i], (i == 3));
    end

    // Reset for 2 cycles while idle; Addr/Dout hold nonzero values before it.
    clr();
    Rst = 1'b1;
    tick(); tick();
    chk("rst_ctl", {Cmd_Ready, Wr_Ready, Rd_Valid, Rd_Last, Busy, Err, BRAM_EN_A, BRAM_WEN_A}, 0);
    chk("rst_addr", BRAM_Addr_A, 0);
    chk("rst_dout", BRAM_Dout_A, 0);
    chk("rst_rdata", Rd_Data, 0);
    Rst = 1'b0;
    tick();
    chk("rst_cmd_ready", Cmd_Ready, 1);

    // Reset in cycle 6 of a 16-beat read with the FIFO backed up.
    clr();
    st_lo = 0; st_hi = 1000;
    cmd(1'b0, 32'h0, 8'd15);
    while (cyc - t0 < 6) tick();
    Rst = 1'b1;
    tick(); tick();
    Rst = 1'b0;
    st_lo = 1; st_hi = 0;
    tick();
    chk("mid_rst_rd_valid", Rd_Valid, 0);
    chk("mid_rst_busy", Busy, 0);
    tick(); tick(); tick();
    chk("mid_rst_rd_valid_later", Rd_Valid, 0);
    clr();
    cmd(1'b0, 32'h20, 8'd0);
    wait_idle();
    chk("single_beats", rb_data.size(), 1);
    if (rb_data.size() == 1) begin
      chk("single_data", rb_data[0], 8);
      chk("single_last", rb_last[0], 1);
    end
    chk("single_first_valid", first_rv, 4);

`ifdef BRAM_ADDR_CHECK_EN
    // Out-of-range then misaligned commands: consumed, Err pulse, no access.
    clr();
    Cmd_Valid = 1'b1; Cmd_Write = 1'b0; Cmd_Addr = 32'h2000; Cmd_Len = 8'd0;
    chk("rej1_ready", Cmd_Ready, 1);
    tick();
    Cmd_Valid = 1'b0;
    chk("rej1_err", Err, 1);
    tick();
    chk("rej1_err_clr", Err, 0);
    Cmd_Valid = 1'b1; Cmd_Write = 1'b1; Cmd_Addr = 32'h0002;
    chk("rej2_ready", Cmd_Ready, 1);
    tick();
    Cmd_Valid = 1'b0;
    chk("rej2_err", Err, 1);
    tick();
    chk("rej2_err_clr", Err, 0);
    repeat (4) tick();
    chk("rej_no_access", acc_rel.size(), 0);
    chk("rej_busy", busy_any, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
